// File: rtl/piso_pkg.sv
// Shared types and defaults for the 8-bit PISO transmitter.
package piso_pkg;
    localparam int WIDTH_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/piso_tx8_if.sv
// Parallel-load handshake and serial output bundle for piso_tx8.
interface piso_tx8_if #(parameter int WIDTH = piso_pkg::WIDTH_DEF);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             sOut;
    logic             sEn;
    logic             frame_done;
    logic             busy;

    modport master (
        output din, load_valid,
        input  load_ready, sOut, sEn, frame_done, busy
    );

    modport slave (
        input  din, load_valid,
        output load_ready, sOut, sEn, frame_done, busy
    );
endinterface

// File: rtl/piso_shreg.sv
// WIDTH-bit register with parallel load and zero-filling right shift.
module piso_shreg #(
    parameter int WIDTH = piso_pkg::WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // load wins over shift so a new frame can start on the last-bit cycle
    always_ff @(posedge clk) begin
        if (!rst_n)     q <= '0;
        else if (load)  q <= d;
        else if (shift) q <= {1'b0, q[WIDTH-1:1]};
    end
endmodule

// File: rtl/piso_tx8.sv
// LSB-first parallel-in serial-out transmitter with a one-word holding register.
module piso_tx8
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic           clc,
    input  logic           R,
    piso_tx8_if.slave      bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic [WIDTH-1:0] sr, sr_d;
    logic             sr_load, sr_shift;
    logic             xfer, last;

    assign bus.load_ready = R && !hold_full;
    assign xfer           = bus.load_valid && bus.load_ready;
    assign last           = (state == SHIFT) && (cnt == CNT_LAST);

    assign bus.sEn        = (state == SHIFT);
    assign bus.sOut       = (state == SHIFT) ? sr[0] : 1'b0;
    assign bus.frame_done = last;
    assign bus.busy       = (state == SHIFT) || hold_full;

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clc),
        .rst_n (R),
        .load  (sr_load),
        .shift (sr_shift),
        .d     (sr_d),
        .q     (sr)
    );

    always_ff @(posedge clc) begin
        if (!R) begin
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hold_n      = hold;
        hold_full_n = hold_full;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_d        = bus.din;
        case (state)
            IDLE: begin
                if (xfer) begin
                    sr_load = 1'b1;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (!last) begin
                    sr_shift = 1'b1;
                    cnt_n    = cnt + 1'b1;
                    if (xfer) begin
                        hold_n      = bus.din;
                        hold_full_n = 1'b1;
                    end
                end else if (hold_full) begin
                    // held word goes first; load_ready is low so no xfer can collide
                    sr_load     = 1'b1;
                    sr_d        = hold;
                    hold_full_n = 1'b0;
                    cnt_n       = '0;
                end else if (xfer) begin
                    sr_load = 1'b1;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/piso_tx8.md
PISO_TX8 -- requirements
Module: piso_tx8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width in bits.
REQ-002 SHALL have port clc, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port R, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port din, input, WIDTH bits: parallel word to transmit.
REQ-005 SHALL have port load_valid, input, 1 bit: din is valid this cycle.
REQ-006 SHALL have port load_ready, output, 1 bit: the block can accept din this cycle.
REQ-007 SHALL have port sOut, output, 1 bit: serial data bit.
REQ-008 SHALL have port sEn, output, 1 bit: sOut carries a valid bit this cycle; the receiver shifts when high.
REQ-009 SHALL have port frame_done, output, 1 bit: high during the cycle that presents the last bit of a word.
REQ-010 SHALL have port busy, output, 1 bit: a word is being shifted, or a word is held waiting.

Function
REQ-011 SHALL transmit LSB first, so that a shift-right receiver with serial-in at the MSB holds the original word after WIDTH enabled shifts.
REQ-012 SHALL complete a transfer on each rising clc where load_valid and load_ready are both high; when load_valid is low, din is ignored.
REQ-013 SHALL drive load_ready as the inverse of hold_full (one-entry holding register) while R is high, and drive it 0 while R is low.
REQ-014 SHALL implement FSM states IDLE and SHIFT.
- IDLE: sEn=0, sOut=0.
- SHIFT: sEn=1, sOut=sr[0].
REQ-015 SHALL, on a transfer in IDLE, load sr<=din, bit count cnt<=0, and enter SHIFT, so the first bit appears exactly 1 cycle after acceptance.
REQ-016 SHALL, on each SHIFT cycle with cnt<WIDTH-1, shift sr right by one and increment cnt.
REQ-017 SHALL assert frame_done combinationally when state=SHIFT and cnt=WIDTH-1.
REQ-018 SHALL, at the end of the last-bit cycle, choose the next word by priority:
- hold_full: load sr from hold, clear hold_full, cnt<=0, stay in SHIFT.
- else, a transfer this cycle: load sr from din, stay in SHIFT.
- else: go to IDLE.
REQ-019 SHALL, on a transfer during SHIFT that is not consumed by REQ-018, store din in hold and set hold_full.
REQ-020 SHALL therefore sustain back-to-back words with no sEn gap between frames.
REQ-021 SHALL drive busy as (state=SHIFT) OR hold_full.
REQ-022 SHALL use a cnt of clog2(WIDTH) bits that wraps only through the reload in REQ-018.

Reset
REQ-023 SHALL, on a rising clc with R=0, set state=IDLE, sr=0, hold=0, hold_full=0, cnt=0, regardless of any operation in progress.
REQ-024 SHALL present these output values the cycle after reset: sOut=0, sEn=0, frame_done=0, busy=0, and load_ready=1 once R is high.
REQ-025 SHALL discard any partial frame and any held word when reset is applied mid-frame; no further bits of that frame are emitted.

Structure
REQ-026 SHALL place the state enum typedef (IDLE, SHIFT) and the default WIDTH constant in a shared package, piso_pkg.
REQ-027 SHALL use one sub-module, piso_shreg: a WIDTH-bit register with synchronous active-low reset, a load enable (parallel din), and a shift enable (right shift, 0 fills the MSB).
REQ-028 SHALL keep the FSM, cnt, and holding register in piso_tx8.

Verification
REQ-029 SHALL cover a single word: accept 8'hA5 in IDLE -> over the next 8 cycles sOut=1,0,1,0,0,1,0,1 with sEn=1; frame_done only on cycle 8; cycle 9 has sEn=0 and busy=0.
REQ-030 SHALL cover back-to-back words: 8'h3C, then 8'hC3 accepted during the first frame -> 16 consecutive sEn cycles; load_ready=0 from the cycle after 8'hC3 is accepted until the hold register drains.
REQ-031 SHALL cover a full buffer: a third word offered with hold full -> load_ready=0 and the word is not transmitted; it is accepted on the first cycle after the second frame starts.
REQ-032 SHALL cover the simultaneous case: with hold empty, a word accepted on the last-bit cycle -> its first bit appears on the very next cycle (no gap).
REQ-033 SHALL cover reset mid-frame: R=0 for 1 cycle after 3 bits of 8'hFF -> sEn=0, sOut=0, busy=0 afterwards, and the next accepted 8'h81 transmits cleanly.
REQ-034 SHALL cover loopback: connect to a shift-right serial-in receiver enabled by sEn -> the receiver holds 8'h5A after one frame of 8'h5A.
